// File: rtl/jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe engine.
// Holds the symbol codes stored in cells and in the macro status, the FSM state codes (the
// numeric values are visible on the estado port) and the turn-toggle helper.
package jogo_pkg;

    localparam logic [1:0] VAZIO  = 2'b00;
    localparam logic [1:0] SIMB_X = 2'b01;
    localparam logic [1:0] SIMB_O = 2'b10;
    localparam logic [1:0] VELHA  = 2'b11;

    typedef enum logic [3:0] {
        StInicial       = 4'h0,
        StPrepara       = 4'h1,
        StEsperaMacro   = 4'h2,
        StRegistraMacro = 4'h3,
        StValidaMacro   = 4'h4,
        StEsperaMicro   = 4'h5,
        StRegistraMicro = 4'h6,
        StValidaMicro   = 4'h7,
        StEscreve       = 4'h8,
        StVerifica      = 4'h9,
        StAtualiza      = 4'hA,
        StTroca         = 4'hB,
        StFim           = 4'hC
    } estado_t;

    function automatic logic [1:0] troca_jogador(input logic [1:0] atual);
        return (atual == SIMB_X) ? SIMB_O : SIMB_X;
    endfunction

endpackage

// File: rtl/verifica_linhas.sv
// Combinational line checker for one SIDE x SIDE board.
// Ports:
//   board      in   SIDE*SIDE*2  2-bit symbol per cell, cell i at bits [2i+1:2i]
//   resultado  out  2            00 open, 01 X wins, 10 O wins, 11 velha (full, no winner)
// A line wins only when all its cells hold the same X or O symbol, so VELHA cells (used in the
// macro status) block every line they sit on.
module verifica_linhas
    import jogo_pkg::*;
#(
    parameter int unsigned SIDE = 3
) (
    input  logic [SIDE*SIDE*2-1:0] board,
    output logic [1:0]             resultado
);

    localparam int LADO   = int'(SIDE);
    localparam int CELLS  = LADO * LADO;
    localparam int LINHAS = 2 * LADO + 2;

    // Lines 0..SIDE-1 are rows, SIDE..2*SIDE-1 columns, then main and anti diagonal.
    function automatic int celula(input int linha, input int k);
        if (linha < LADO) begin
            return linha * LADO + k;
        end else if (linha < 2 * LADO) begin
            return k * LADO + (linha - LADO);
        end else if (linha == 2 * LADO) begin
            return k * LADO + k;
        end else begin
            return k * LADO + (LADO - 1 - k);
        end
    endfunction

    logic [1:0] vencedor;
    logic [1:0] simb;
    logic       iguais;
    logic       tem_vazio;

    always_comb begin
        vencedor  = VAZIO;
        simb      = VAZIO;
        iguais    = 1'b0;
        tem_vazio = 1'b0;
        for (int c = 0; c < CELLS; c++) begin
            if (board[2*c +: 2] == VAZIO) tem_vazio = 1'b1;
        end
        for (int l = 0; l < LINHAS; l++) begin
            simb   = board[2*celula(l, 0) +: 2];
            iguais = (simb == SIMB_X) || (simb == SIMB_O);
            for (int k = 1; k < LADO; k++) begin
                if (board[2*celula(l, k) +: 2] != simb) iguais = 1'b0;
            end
            if (iguais && (vencedor == VAZIO)) vencedor = simb;
        end
        if (vencedor != VAZIO) begin
            resultado = vencedor;
        end else if (tem_vazio) begin
            resultado = VAZIO;
        end else begin
            resultado = VELHA;
        end
    end

endmodule

// File: rtl/circuito_jogo_param.sv
// Ultimate tic-tac-toe game engine: SIDE x SIDE macro board of SIDE x SIDE micro boards.
// Holds the board storage, button edge detection, per-turn timeout and the game FSM, and
// publishes each completed move on a valid/ack event port.
// Ports:
//   clock, reset        system clock; synchronous active-low reset
//   iniciar             starts a game from INICIAL or FIM
//   botoes / leds       one bit per cell position; leds show occupancy of the active micro board
//   pronto, jogar_*     state flags (FIM, ESPERA_MACRO, ESPERA_MICRO)
//   jogador             01 = X, 10 = O
//   macro_sel/micro_sel registered selections; estado = FSM state code
//   resultado_macro     status of last written macro; resultado_jogo = whole game
//   evento_valido/ack   move event handshake; payload stable while evento_valido is high
module circuito_jogo_param
    import jogo_pkg::*;
#(
    parameter int unsigned SIDE           = 3,
    parameter int unsigned TIMEOUT_CICLOS = 50000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic [SIDE*SIDE-1:0] botoes,
    output logic [SIDE*SIDE-1:0] leds,
    output logic                 pronto,
    output logic                 jogar_macro,
    output logic                 jogar_micro,
    output logic [1:0]           jogador,
    output logic [3:0]           macro_sel,
    output logic [3:0]           micro_sel,
    output logic [3:0]           estado,
    output logic [1:0]           resultado_macro,
    output logic [1:0]           resultado_jogo,
    output logic                 evento_valido,
    input  logic                 evento_ack
);

    localparam int CELLS = int'(SIDE * SIDE);
    localparam int TW    = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    estado_t                  estado_q, estado_d;
    logic [CELLS*CELLS*2-1:0] tabuleiro_q, tabuleiro_d;
    logic [CELLS*2-1:0]       status_q, status_d;
    logic [1:0]               jogador_q, jogador_d;
    logic [3:0]               macro_sel_q, macro_sel_d;
    logic [3:0]               micro_sel_q, micro_sel_d;
    logic [3:0]               indice_q, indice_d;
    logic [CELLS-1:0]         botoes_ant_q;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     evento_q, evento_d;
    logic [1:0]               res_macro_q, res_macro_d;
    logic [1:0]               res_jogo_q, res_jogo_d;

    logic [CELLS*2-1:0] micro_ativo;
    logic [1:0]         res_micro_comb;
    logic [1:0]         res_macro_comb;
    logic [1:0]         celula_sel;
    logic [1:0]         status_sel;
    logic [1:0]         status_destino;
    logic [3:0]         indice;
    logic               jogada;
    logic               em_espera;
    logic               timeout;
    int                 pos_celula;

    assign pos_celula     = int'(macro_sel_q) * CELLS + int'(micro_sel_q);
    assign micro_ativo    = tabuleiro_q[int'(macro_sel_q)*CELLS*2 +: CELLS*2];
    assign celula_sel     = tabuleiro_q[pos_celula*2 +: 2];
    assign status_sel     = status_q[int'(macro_sel_q)*2 +: 2];
    assign status_destino = status_q[int'(micro_sel_q)*2 +: 2];

    verifica_linhas #(.SIDE(SIDE)) u_verifica_micro (
        .board     (micro_ativo),
        .resultado (res_micro_comb)
    );

    verifica_linhas #(.SIDE(SIDE)) u_verifica_macro (
        .board     (status_q),
        .resultado (res_macro_comb)
    );

    // A move is a rising press from all-released to exactly one button.
    assign jogada = (botoes_ant_q == '0) && (botoes != '0) &&
                    ((botoes & (botoes - CELLS'(1))) == '0);

    always_comb begin
        indice = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (botoes[i]) indice = 4'(i);
        end
    end

    assign em_espera = (estado_q == StEsperaMacro) || (estado_q == StEsperaMicro);
    // A press landing on the last timer cycle still counts as a move.
    assign timeout   = em_espera && !jogada && (timer_q == TIMER_MAX);

    always_comb begin
        estado_d    = estado_q;
        tabuleiro_d = tabuleiro_q;
        status_d    = status_q;
        jogador_d   = jogador_q;
        macro_sel_d = macro_sel_q;
        micro_sel_d = micro_sel_q;
        indice_d    = indice_q;
        evento_d    = evento_q;
        res_macro_d = res_macro_q;
        res_jogo_d  = res_jogo_q;
        timer_d     = '0;

        case (estado_q)
            StInicial: begin
                if (iniciar) estado_d = StPrepara;
            end
            StPrepara: begin
                tabuleiro_d = '0;
                status_d    = '0;
                res_macro_d = VAZIO;
                res_jogo_d  = VAZIO;
                jogador_d   = SIMB_X;
                macro_sel_d = '0;
                micro_sel_d = '0;
                estado_d    = StEsperaMacro;
            end
            StEsperaMacro: begin
                if (jogada) begin
                    indice_d = indice;
                    estado_d = StRegistraMacro;
                end else if (timeout) begin
                    jogador_d = troca_jogador(jogador_q);
                end
            end
            StRegistraMacro: begin
                macro_sel_d = indice_q;
                estado_d    = StValidaMacro;
            end
            StValidaMacro: begin
                estado_d = (status_sel == VAZIO) ? StEsperaMicro : StEsperaMacro;
            end
            StEsperaMicro: begin
                if (jogada) begin
                    indice_d = indice;
                    estado_d = StRegistraMicro;
                end else if (timeout) begin
                    jogador_d = troca_jogador(jogador_q);
                    estado_d  = StEsperaMacro;
                end
            end
            StRegistraMicro: begin
                micro_sel_d = indice_q;
                estado_d    = StValidaMicro;
            end
            StValidaMicro: begin
                estado_d = (celula_sel == VAZIO) ? StEscreve : StEsperaMicro;
            end
            StEscreve: begin
                tabuleiro_d[pos_celula*2 +: 2] = jogador_q;
                estado_d = StVerifica;
            end
            StVerifica: begin
                status_d[int'(macro_sel_q)*2 +: 2] = res_micro_comb;
                res_macro_d = res_micro_comb;
                estado_d    = StAtualiza;
            end
            StAtualiza: begin
                res_jogo_d = res_macro_comb;
                evento_d   = 1'b1;
                estado_d   = StTroca;
            end
            StTroca: begin
                if (evento_ack) begin
                    evento_d = 1'b0;
                    if (res_jogo_q != VAZIO) begin
                        estado_d = StFim;
                    end else begin
                        jogador_d = troca_jogador(jogador_q);
                        // A closed destination macro gives the next player a free choice.
                        if (status_destino != VAZIO) begin
                            estado_d = StEsperaMacro;
                        end else begin
                            macro_sel_d = micro_sel_q;
                            estado_d    = StEsperaMicro;
                        end
                    end
                end
            end
            StFim: begin
                if (iniciar) estado_d = StPrepara;
            end
            default: estado_d = StInicial;
        endcase

        // Counts only while staying in the same wait state; any entry restarts it.
        if (em_espera && (estado_d == estado_q) && !timeout) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tabuleiro_q  <= '0;
            status_q     <= '0;
            jogador_q    <= SIMB_X;
            macro_sel_q  <= '0;
            micro_sel_q  <= '0;
            indice_q     <= '0;
            botoes_ant_q <= '0;
            timer_q      <= '0;
            evento_q     <= 1'b0;
            res_macro_q  <= VAZIO;
            res_jogo_q   <= VAZIO;
        end else begin
            tabuleiro_q  <= tabuleiro_d;
            status_q     <= status_d;
            jogador_q    <= jogador_d;
            macro_sel_q  <= macro_sel_d;
            micro_sel_q  <= micro_sel_d;
            indice_q     <= indice_d;
            botoes_ant_q <= botoes;
            timer_q      <= timer_d;
            evento_q     <= evento_d;
            res_macro_q  <= res_macro_d;
            res_jogo_q   <= res_jogo_d;
        end
    end

    always_comb begin
        leds = '0;
        for (int i = 0; i < CELLS; i++) begin
            leds[i] = (micro_ativo[2*i +: 2] != VAZIO);
        end
    end

    assign pronto          = (estado_q == StFim);
    assign jogar_macro     = (estado_q == StEsperaMacro);
    assign jogar_micro     = (estado_q == StEsperaMicro);
    assign jogador         = jogador_q;
    assign macro_sel       = macro_sel_q;
    assign micro_sel       = micro_sel_q;
    assign estado          = estado_q;
    assign resultado_macro = res_macro_q;
    assign resultado_jogo  = res_jogo_q;
    assign evento_valido   = evento_q;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for circuito_jogo_param with SIDE=3 and a 20-cycle turn timeout.
// Plays one scripted game (timing, ignored presses, timeout, free choice, win and FIM) and
// ends with a mid-game reset.
module tb_circuito_jogo_param;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       iniciar    = 1'b0;
    logic       evento_ack = 1'b0;
    logic [8:0] botoes     = '0;

    logic [8:0] leds;
    logic       pronto, jogar_macro, jogar_micro, evento_valido;
    logic [1:0] jogador, resultado_macro, resultado_jogo;
    logic [3:0] macro_sel, micro_sel, estado;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] jog_esp = 2'b01;

    always #5 clock = ~clock;

    circuito_jogo_param #(
        .SIDE           (3),
        .TIMEOUT_CICLOS (20)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .botoes          (botoes),
        .leds            (leds),
        .pronto          (pronto),
        .jogar_macro     (jogar_macro),
        .jogar_micro     (jogar_micro),
        .jogador         (jogador),
        .macro_sel       (macro_sel),
        .micro_sel       (micro_sel),
        .estado          (estado),
        .resultado_macro (resultado_macro),
        .resultado_jogo  (resultado_jogo),
        .evento_valido   (evento_valido),
        .evento_ack      (evento_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int idx);
        botoes = 9'b1 << idx;
        tick();
        botoes = '0;
        tick();
    endtask

    task automatic wait_estado(input string tag, input logic [3:0] alvo);
        int n;
        n = 0;
        while (estado !== alvo && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(estado), 32'(alvo));
    endtask

    // One full move; presses the macro first when the DUT offers a free choice.
    task automatic jogada(input int m, input int c, input logic [1:0] rm, input logic [1:0] rj,
                          input bit dar_ack);
        if (estado == 4'h2) begin
            press(m);
            wait_estado("entra_micro", 4'h5);
        end
        check_eq("macro_ativo", 32'(macro_sel), 32'(m));
        press(c);
        wait_estado("chega_troca", 4'hB);
        check_eq("ev_valido", 32'(evento_valido), 32'(1));
        check_eq("ev_macro", 32'(macro_sel), 32'(m));
        check_eq("ev_micro", 32'(micro_sel), 32'(c));
        check_eq("ev_jogador", 32'(jogador), 32'(jog_esp));
        check_eq("ev_res_macro", 32'(resultado_macro), 32'(rm));
        check_eq("ev_res_jogo", 32'(resultado_jogo), 32'(rj));
        if (dar_ack) begin
            evento_ack = 1'b1;
            tick();
            evento_ack = 1'b0;
            check_eq("ev_baixa", 32'(evento_valido), 32'(0));
            if (rj == 2'b00) jog_esp = (jog_esp == 2'b01) ? 2'b10 : 2'b01;
        end
    endtask

    initial begin
        // Reset
        tick_n(2);
        check_eq("rst_estado", 32'(estado), 32'(0));
        check_eq("rst_jogador", 32'(jogador), 32'(1));
        check_eq("rst_evento", 32'(evento_valido), 32'(0));
        check_eq("rst_leds", 32'(leds), 32'(0));
        check_eq("rst_pronto", 32'(pronto), 32'(0));
        check_eq("rst_macro_sel", 32'(macro_sel), 32'(0));

        reset   = 1'b1;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_eq("prepara", 32'(estado), 32'(1));
        tick();
        check_eq("espera_macro", 32'(estado), 32'(2));
        check_eq("jogar_macro", 32'(jogar_macro), 32'(1));

        // First move with exact latency: macro 4, micro 0
        press(4);
        tick();
        check_eq("espera_micro", 32'(estado), 32'(5));
        check_eq("macro4_sel", 32'(macro_sel), 32'(4));
        check_eq("jogar_micro", 32'(jogar_micro), 32'(1));
        botoes = 9'b1;
        tick();
        botoes = '0;
        tick();
        check_eq("leds_lat1", 32'(leds), 32'(0));
        tick();
        check_eq("leds_lat2", 32'(leds), 32'(0));
        tick();
        check_eq("leds_lat3", 32'(leds), 32'(9'h001));
        tick();
        check_eq("ev_lat4", 32'(evento_valido), 32'(0));
        tick();
        check_eq("ev_lat5", 32'(evento_valido), 32'(1));
        check_eq("ev1_estado", 32'(estado), 32'(4'hB));
        check_eq("ev1_macro", 32'(macro_sel), 32'(4));
        check_eq("ev1_micro", 32'(micro_sel), 32'(0));
        check_eq("ev1_jogador", 32'(jogador), 32'(1));
        check_eq("ev1_res_macro", 32'(resultado_macro), 32'(0));
        check_eq("ev1_res_jogo", 32'(resultado_jogo), 32'(0));
        evento_ack = 1'b1;
        tick();
        evento_ack = 1'b0;
        jog_esp = 2'b10;
        check_eq("ack1_jogador", 32'(jogador), 32'(2));
        check_eq("ack1_estado", 32'(estado), 32'(5));
        check_eq("ack1_macro", 32'(macro_sel), 32'(0));
        check_eq("ack1_evento", 32'(evento_valido), 32'(0));

        // Two buttons at once are not a move
        botoes = 9'b000000011;
        tick();
        botoes = '0;
        tick();
        check_eq("multi_estado", 32'(estado), 32'(5));
        check_eq("multi_leds", 32'(leds), 32'(0));

        // O plays macro 0 cell 4, sending X to macro 4
        jogada(0, 4, 2'b00, 2'b00, 1'b1);
        check_eq("o_estado", 32'(estado), 32'(5));
        check_eq("o_macro", 32'(macro_sel), 32'(4));

        // X presses its occupied cell 0 in macro 4
        press(0);
        tick();
        check_eq("ocup_estado", 32'(estado), 32'(5));
        check_eq("ocup_leds", 32'(leds), 32'(9'h001));
        check_eq("ocup_evento", 32'(evento_valido), 32'(0));
        check_eq("ocup_jogador", 32'(jogador), 32'(1));

        // Timeout: 20 idle cycles in ESPERA_MICRO
        tick_n(19);
        check_eq("pre_timeout", 32'(estado), 32'(5));
        tick();
        jog_esp = 2'b10;
        check_eq("timeout_estado", 32'(estado), 32'(2));
        check_eq("timeout_jogador", 32'(jogador), 32'(2));
        check_eq("timeout_evento", 32'(evento_valido), 32'(0));
        check_eq("timeout_leds", 32'(leds), 32'(9'h001));

        // Scripted game: X takes macros 0, 4, 8
        jogada(3, 0, 2'b00, 2'b00, 1'b1);
        jogada(0, 1, 2'b00, 2'b00, 1'b1);
        jogada(1, 0, 2'b00, 2'b00, 1'b1);
        jogada(0, 2, 2'b00, 2'b00, 1'b1);
        jogada(2, 4, 2'b00, 2'b00, 1'b1);
        jogada(4, 3, 2'b00, 2'b00, 1'b1);
        jogada(3, 8, 2'b00, 2'b00, 1'b1);
        jogada(8, 1, 2'b00, 2'b00, 1'b1);
        jogada(1, 8, 2'b00, 2'b00, 1'b1);
        jogada(8, 2, 2'b00, 2'b00, 1'b1);
        jogada(2, 0, 2'b00, 2'b00, 1'b1);
        jogada(0, 0, 2'b01, 2'b00, 1'b1);
        check_eq("livre_estado", 32'(estado), 32'(2));
        check_eq("livre_jogador", 32'(jogador), 32'(2));
        jogada(6, 4, 2'b00, 2'b00, 1'b1);
        jogada(4, 6, 2'b01, 2'b00, 1'b1);
        jogada(6, 8, 2'b00, 2'b00, 1'b1);
        jogada(8, 0, 2'b01, 2'b01, 1'b0);

        // Event held without ack
        tick_n(5);
        check_eq("stall_estado", 32'(estado), 32'(4'hB));
        check_eq("stall_evento", 32'(evento_valido), 32'(1));
        evento_ack = 1'b1;
        tick();
        evento_ack = 1'b0;
        check_eq("fim_estado", 32'(estado), 32'(4'hC));
        check_eq("fim_pronto", 32'(pronto), 32'(1));
        check_eq("fim_evento", 32'(evento_valido), 32'(0));
        check_eq("fim_jogo", 32'(resultado_jogo), 32'(1));

        // New game clears the boards, then reset mid-move
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        check_eq("novo_estado", 32'(estado), 32'(2));
        check_eq("novo_leds", 32'(leds), 32'(0));
        check_eq("novo_jogo", 32'(resultado_jogo), 32'(0));
        check_eq("novo_jogador", 32'(jogador), 32'(1));
        botoes = 9'b1 << 4;
        tick();
        botoes = '0;
        check_eq("meio_registra", 32'(estado), 32'(3));
        reset = 1'b0;
        tick();
        check_eq("meio_rst_estado", 32'(estado), 32'(0));
        check_eq("meio_rst_macro", 32'(macro_sel), 32'(0));
        reset = 1'b1;
        tick();
        check_eq("meio_rst_fica", 32'(estado), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
